bcd_counter4: RTL and testbench

BCD_COUNTER4 -- requirements
Module: bcd_counter4

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_counter4_if.sv | 33 +++
 rtl/bcd_digit.sv | 39 +++
 rtl/bcd_counter4.sv | 94 +++++++++
 tb/tb_bcd_counter4.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the four-digit BCD counter.
//   bcd_digit_t  - one BCD digit (4 bits, legal values 0..9)
//   BCD_MAX/MIN  - digit limits
//   BCD_DIGITS   - number of digits in the counter
//   bcd_clamp    - saturates a raw nibble to a legal BCD digit
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam bcd_digit_t BCD_MIN    = 4'd0;
    localparam int         BCD_DIGITS = 4;

    function automatic bcd_digit_t bcd_clamp(input logic [3:0] raw);
        return (raw > BCD_MAX) ? BCD_MAX : raw;
    endfunction

endpackage

// File: rtl/bcd_counter4_if.sv
// bcd_counter4_if: command and status bundle of the BCD counter.
//   Commands (master -> slave): inc, dec, clr, load, load_val[15:0]
//   Status   (slave -> master): dig3..dig0, carry, borrow, at_max, at_min, load_err
interface bcd_counter4_if;
    import bcd_pkg::*;

    logic        inc;
    logic        dec;
    logic        clr;
    logic        load;
    logic [15:0] load_val;

    bcd_digit_t  dig3;
    bcd_digit_t  dig2;
    bcd_digit_t  dig1;
    bcd_digit_t  dig0;
    logic        carry;
    logic        borrow;
    logic        at_max;
    logic        at_min;
    logic        load_err;

    modport master (
        output inc, dec, clr, load, load_val,
        input  dig3, dig2, dig1, dig0, carry, borrow, at_max, at_min, load_err
    );

    modport slave (
        input  inc, dec, clr, load, load_val,
        output dig3, dig2, dig1, dig0, carry, borrow, at_max, at_min, load_err
    );

endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one registered BCD digit with ripple in/out.
//   clk, rst_n      - clock, async active-low reset
//   clr, ld, ld_val - synchronous clear / load (ld_val must already be 0..9)
//   up_in, dn_in    - step request from the lower digit (or the top for digit 0)
//   q               - current digit value
//   up_out, dn_out  - combinational ripple to the next higher digit (9->0 / 0->9)
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ld,
    input  bcd_digit_t ld_val,
    input  logic       up_in,
    input  logic       dn_in,
    output bcd_digit_t q,
    output logic       up_out,
    output logic       dn_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_MIN;
        end else if (clr) begin
            q <= BCD_MIN;
        end else if (ld) begin
            q <= ld_val;
        end else if (up_in) begin
            q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
        end else if (dn_in) begin
            q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
        end
    end

    assign up_out = up_in && (q == BCD_MAX);
    assign dn_out = dn_in && (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter4.sv
// bcd_counter4: four-digit BCD up/down counter with clear, clamped load,
// wrap or saturate at the limits, and registered carry/borrow/load_err pulses.
//   WRAP  - 1: wrap 9999<->0000, 0: hold at the limit (pulses still fire)
//   clk   - rising-edge clock
//   rst_n - async active-low reset
//   bus   - bcd_counter4_if.slave (commands in, digits and status out)
module bcd_counter4
    import bcd_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_counter4_if.slave   bus
);

    bcd_digit_t            q        [BCD_DIGITS];
    bcd_digit_t            ld_vals  [BCD_DIGITS];
    logic [BCD_DIGITS:0]   up_chain;
    logic [BCD_DIGITS:0]   dn_chain;

    logic load_cmd;
    logic step_ok;
    logic up_cmd;
    logic dn_cmd;
    logic at_max;
    logic at_min;
    logic any_clamped;
    logic carry_nxt;
    logic borrow_nxt;

    // clr beats load beats inc/dec; inc and dec together cancel.
    assign load_cmd = bus.load && !bus.clr;
    assign step_ok  = !bus.clr && !bus.load && (bus.inc ^ bus.dec);
    assign up_cmd   = step_ok && bus.inc;
    assign dn_cmd   = step_ok && bus.dec;

    assign at_max = (q[3] == BCD_MAX) && (q[2] == BCD_MAX) &&
                    (q[1] == BCD_MAX) && (q[0] == BCD_MAX);
    assign at_min = (q[3] == BCD_MIN) && (q[2] == BCD_MIN) &&
                    (q[1] == BCD_MIN) && (q[0] == BCD_MIN);

    // In saturate mode the step never enters the chain at the limit, so the
    // digits hold while the pulse is still generated below.
    assign up_chain[0] = up_cmd && (WRAP || !at_max);
    assign dn_chain[0] = dn_cmd && (WRAP || !at_min);

    always_comb begin
        any_clamped = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            ld_vals[i]  = bcd_clamp(bus.load_val[4*i +: 4]);
            any_clamped = any_clamped || (bus.load_val[4*i +: 4] > BCD_MAX);
        end
    end

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (bus.clr),
            .ld     (load_cmd),
            .ld_val (ld_vals[g]),
            .up_in  (up_chain[g]),
            .dn_in  (dn_chain[g]),
            .q      (q[g]),
            .up_out (up_chain[g+1]),
            .dn_out (dn_chain[g+1])
        );
    end

    // When wrapping, the ripple out of the top digit is exactly the carry/borrow.
    assign carry_nxt  = WRAP ? up_chain[BCD_DIGITS] : (up_cmd && at_max);
    assign borrow_nxt = WRAP ? dn_chain[BCD_DIGITS] : (dn_cmd && at_min);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.carry    <= 1'b0;
            bus.borrow   <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            bus.carry    <= carry_nxt;
            bus.borrow   <= borrow_nxt;
            bus.load_err <= load_cmd && any_clamped;
        end
    end

    assign bus.dig3   = q[3];
    assign bus.dig2   = q[2];
    assign bus.dig1   = q[1];
    assign bus.dig0   = q[0];
    assign bus.at_max = at_max;
    assign bus.at_min = at_min;

endmodule

// File: tb/tb_bcd_counter4.sv
// tb_bcd_counter4: directed test of bcd_counter4 in wrap (dut_w) and
// saturate (dut_s) configurations, both driven with the same commands.
module tb_bcd_counter4;

    logic clk;
    logic rst_n;

    bcd_counter4_if if_w ();
    bcd_counter4_if if_s ();

    bcd_counter4 #(.WRAP(1'b1)) dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w));
    bcd_counter4 #(.WRAP(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // {digits, carry, borrow, load_err, at_max, at_min}
    logic [20:0] obs_w;
    logic [20:0] obs_s;
    assign obs_w = {if_w.dig3, if_w.dig2, if_w.dig1, if_w.dig0,
                    if_w.carry, if_w.borrow, if_w.load_err, if_w.at_max, if_w.at_min};
    assign obs_s = {if_s.dig3, if_s.dig2, if_s.dig1, if_s.dig0,
                    if_s.carry, if_s.borrow, if_s.load_err, if_s.at_max, if_s.at_min};

    function automatic logic [20:0] ex(input logic [15:0] d, input logic c,
                                       input logic b, input logic le);
        return {d, c, b, le, d == 16'h9999, d == 16'h0000};
    endfunction

    task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got dig=%h c/b/le/max/min=%b expected dig=%h c/b/le/max/min=%b",
                     tag, obs[20:5], obs[4:0], exp[20:5], exp[4:0]);
        end
    endtask

    task automatic step(input logic i, input logic d, input logic c,
                        input logic l, input logic [15:0] v);
        @(negedge clk);
        if_w.inc = i; if_w.dec = d; if_w.clr = c; if_w.load = l; if_w.load_val = v;
        if_s.inc = i; if_s.dec = d; if_s.clr = c; if_s.load = l; if_s.load_val = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        if_w.inc = 0; if_w.dec = 0; if_w.clr = 0; if_w.load = 0; if_w.load_val = '0;
        if_s.inc = 0; if_s.dec = 0; if_s.clr = 0; if_s.load = 0; if_s.load_val = '0;
        #12;
        chk("reset_w", obs_w, ex(16'h0000, 0, 0, 0));
        chk("reset_s", obs_s, ex(16'h0000, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // ten inc pulses
        step(1, 0, 0, 0, 16'h0);
        chk("inc1_w", obs_w, ex(16'h0001, 0, 0, 0));
        chk("inc1_s", obs_s, ex(16'h0001, 0, 0, 0));
        step(0, 0, 0, 0, 16'h0);
        for (int k = 0; k < 9; k++) begin
            step(1, 0, 0, 0, 16'h0);
            step(0, 0, 0, 0, 16'h0);
        end
        chk("inc10_w", obs_w, ex(16'h0010, 0, 0, 0));
        chk("inc10_s", obs_s, ex(16'h0010, 0, 0, 0));

        // full ripple up and down
        step(0, 0, 0, 1, 16'h0999);
        chk("ld0999_w", obs_w, ex(16'h0999, 0, 0, 0));
        step(1, 0, 0, 0, 16'h0);
        chk("rip_up_w", obs_w, ex(16'h1000, 0, 0, 0));
        chk("rip_up_s", obs_s, ex(16'h1000, 0, 0, 0));
        step(0, 1, 0, 0, 16'h0);
        chk("rip_dn_w", obs_w, ex(16'h0999, 0, 0, 0));
        chk("rip_dn_s", obs_s, ex(16'h0999, 0, 0, 0));

        // upper limit
        step(0, 0, 0, 1, 16'h9999);
        chk("ld9999_w", obs_w, ex(16'h9999, 0, 0, 0));
        step(1, 0, 0, 0, 16'h0);
        chk("wrap_up_w", obs_w, ex(16'h0000, 1, 0, 0));
        chk("sat_up_s",  obs_s, ex(16'h9999, 1, 0, 0));
        step(0, 0, 0, 0, 16'h0);
        chk("carry_end_w", obs_w, ex(16'h0000, 0, 0, 0));
        chk("carry_end_s", obs_s, ex(16'h9999, 0, 0, 0));

        // lower limit
        step(0, 0, 1, 0, 16'h0);
        chk("clr_s", obs_s, ex(16'h0000, 0, 0, 0));
        step(0, 1, 0, 0, 16'h0);
        chk("wrap_dn_w", obs_w, ex(16'h9999, 0, 1, 0));
        chk("sat_dn_s",  obs_s, ex(16'h0000, 0, 1, 0));
        step(0, 0, 0, 0, 16'h0);
        chk("borrow_end_w", obs_w, ex(16'h9999, 0, 0, 0));
        chk("borrow_end_s", obs_s, ex(16'h0000, 0, 0, 0));

        // simultaneous commands
        step(0, 0, 0, 1, 16'h0500);
        step(1, 1, 0, 0, 16'h0);
        chk("incdec_w", obs_w, ex(16'h0500, 0, 0, 0));
        chk("incdec_s", obs_s, ex(16'h0500, 0, 0, 0));
        step(1, 0, 1, 1, 16'h1234);
        chk("clr_prio_w", obs_w, ex(16'h0000, 0, 0, 0));
        step(1, 0, 0, 1, 16'h1234);
        chk("ld_prio_w", obs_w, ex(16'h1234, 0, 0, 0));
        step(0, 0, 0, 1, 16'h1A3F);
        chk("ld_clamp_w", obs_w, ex(16'h1939, 0, 0, 1));
        chk("ld_clamp_s", obs_s, ex(16'h1939, 0, 0, 1));
        step(0, 0, 0, 0, 16'h0);
        chk("lderr_end_w", obs_w, ex(16'h1939, 0, 0, 0));

        // held inc steps every clock, then async reset between edges
        step(1, 0, 0, 0, 16'h0);
        chk("hold1_w", obs_w, ex(16'h1940, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("hold2_w", obs_w, ex(16'h1941, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_w", obs_w, ex(16'h0000, 0, 0, 0));
        chk("async_rst_s", obs_s, ex(16'h0000, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("resume1_w", obs_w, ex(16'h0001, 0, 0, 0));
        chk("resume1_s", obs_s, ex(16'h0001, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("resume2_w", obs_w, ex(16'h0002, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
